// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch constants: reset PC / text base, NOP word, ROM depth, FSM states.
package instruction_fetch_unit_pkg;
  localparam int          DATA_W_DEF    = 32;
  localparam int          ROM_DEPTH_DEF = 64;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0040_0000;
  localparam logic [31:0] NOP           = 32'h0000_0000;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: pipeline control in, instruction memory, IF/ID register out.
interface instruction_fetch_unit_if #(parameter int DATA_WIDTH = 32);
  logic                  stall;
  logic                  flush;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  jump;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] imem_data;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] if_id_instr;
  logic [DATA_WIDTH-1:0] if_id_pc_plus4;
  logic                  if_id_valid;
  logic                  fetch_fault;

  // fetch unit side
  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target, imem_data,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_fault
  );

  // pipeline / memory side
  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_fault
  );
endinterface

// File: rtl/instruction_fetch_unit_pc_next_mux.sv
// Next-PC selection (jump > branch > PC+4), word alignment and range check.
module pc_next_mux
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_W_DEF,
  parameter int                    ROM_DEPTH  = ROM_DEPTH_DEF,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEF)
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  redirect,
  output logic                  misaligned,
  output logic                  out_of_range
);
  // One bit wider so the end of the text segment cannot wrap to zero.
  localparam logic [DATA_WIDTH:0] PC_LIMIT = {1'b0, RESET_PC} + (DATA_WIDTH+1)'(4 * ROM_DEPTH);

  logic [DATA_WIDTH-1:0] raw_pc;

  // Pick the raw target, force word alignment, flag misalignment and range faults.
  // PC+4 wrapping past the top of memory lands below RESET_PC and is caught here.
  always_comb begin
    raw_pc = pc + DATA_WIDTH'(4);
    if (jump)              raw_pc = jump_target;
    else if (branch_taken) raw_pc = branch_target;
    redirect     = jump | branch_taken;
    misaligned   = redirect && (raw_pc[1:0] != 2'b00);
    next_pc      = {raw_pc[DATA_WIDTH-1:2], 2'b00};
    out_of_range = (next_pc < RESET_PC) || ({1'b0, next_pc} >= PC_LIMIT);
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register and FILL/RUN/HALT control.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_W_DEF,
  parameter int                    ROM_DEPTH  = ROM_DEPTH_DEF,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEF)
) (
  input logic                  clk,
  input logic                  reset,
  instruction_fetch_unit_if.master bus
);
  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc4_q;
  logic                  valid_q;
  logic                  fault_q;

  logic [DATA_WIDTH-1:0] next_pc;
  logic                  redirect;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  advance;

  pc_next_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .ROM_DEPTH (ROM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_pc_next_mux (
    .pc           (pc),
    .jump         (bus.jump),
    .jump_target  (bus.jump_target),
    .branch_taken (bus.branch_taken),
    .branch_target(bus.branch_target),
    .next_pc      (next_pc),
    .redirect     (redirect),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  // Flush and redirects override a stall; otherwise a stall freezes everything.
  assign advance = redirect | bus.flush | ~bus.stall;

  // Fetch FSM with registered PC, IF/ID contents and sticky fault.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      pc      <= RESET_PC;
      instr_q <= DATA_WIDTH'(NOP);
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        // Bubble cycle: PC stays at the reset vector, nothing enters IF/ID.
        FILL: begin
          state   <= RUN;
          valid_q <= 1'b0;
        end
        RUN: begin
          if (advance) begin
            pc <= next_pc;
            if (out_of_range) begin
              state   <= HALT;
              fault_q <= 1'b1;
              instr_q <= DATA_WIDTH'(NOP);
              pc4_q   <= '0;
              valid_q <= 1'b0;
            end else begin
              if (misaligned) fault_q <= 1'b1;
              if (redirect | bus.flush) begin
                instr_q <= DATA_WIDTH'(NOP);
                pc4_q   <= '0;
                valid_q <= 1'b0;
              end else begin
                instr_q <= bus.imem_data;
                pc4_q   <= pc + DATA_WIDTH'(4);
                valid_q <= 1'b1;
              end
            end
          end
        end
        // Dead until reset; IF/ID already holds a NOP from the faulting edge.
        HALT: ;
        default: state <= FILL;
      endcase
    end
  end

  assign bus.imem_addr      = pc;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.fetch_fault    = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a behavioural fetch model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam logic [31:0] LIMIT = 32'h0040_0100;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [31:0] rom [64];

  instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus();

  instruction_fetch_unit #(
    .DATA_WIDTH(32), .ROM_DEPTH(64), .RESET_PC(32'h0040_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a >= BASE && a < LIMIT) return rom[a[7:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign bus.imem_data = rom_word(bus.imem_addr);

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_fault;
  bit          m_filling, m_halted;

  task automatic model_reset();
    m_pc = BASE; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0;
    m_filling = 1; m_halted = 0;
  endtask

  // One clock edge of the fetch stage, expressed directly from its rules.
  task automatic model_step(input logic s, f, b, input logic [31:0] bt,
                            input logic j, input logic [31:0] jt);
    logic [31:0] tgt;
    bit redir;
    if (m_halted) return;
    if (m_filling) begin m_filling = 0; return; end
    redir = j || b;
    if (s && !redir && !f) return;
    tgt = j ? jt : (b ? bt : m_pc + 32'd4);
    if (redir && (tgt % 4) != 0) begin m_fault = 1; tgt = tgt - (tgt % 4); end
    if (tgt < BASE || tgt >= LIMIT) begin
      m_fault = 1; m_halted = 1; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (redir || f) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else begin
      m_instr = rom_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1;
    end
    m_pc = tgt;
  endtask

  // Drive inputs, take one rising edge, advance the model, settle on the falling edge.
  task automatic tick(input logic s, f, b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    bus.stall = s; bus.flush = f; bus.branch_taken = b; bus.branch_target = bt;
    bus.jump = j; bus.jump_target = jt;
    @(posedge clk);
    model_step(s, f, b, bt, j, jt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.jump = 0;
    bus.branch_target = 0; bus.jump_target = 0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    n_checks++; if (bus.imem_addr !== BASE) $display("FAIL reset_addr got %h exp %h", bus.imem_addr, BASE); else n_pass++;
    n_checks++; if (bus.if_id_instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", bus.if_id_instr); else n_pass++;
    n_checks++; if (bus.if_id_pc_plus4 !== 32'h0) $display("FAIL reset_pc4 got %h exp 0", bus.if_id_pc_plus4); else n_pass++;
    n_checks++; if (bus.if_id_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.if_id_valid); else n_pass++;
    n_checks++; if (bus.fetch_fault !== 1'b0) $display("FAIL reset_fault got %b exp 0", bus.fetch_fault); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Address presented each cycle, and whether the fetch issued in that cycle lands valid in IF/ID.
  task automatic test_fill();
    logic [31:0] ea [4] = '{32'h0040_0000, 32'h0040_0000, 32'h0040_0004, 32'h0040_0008};
    logic        ev [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.imem_addr !== ea[k]) $display("FAIL fill_addr[%0d] got %h exp %h", k, bus.imem_addr, ea[k]); else n_pass++;
      tick(0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.if_id_valid !== ev[k]) $display("FAIL fill_valid[%0d] got %b exp %b", k, bus.if_id_valid, ev[k]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.imem_addr !== 32'h0040_0008) $display("FAIL stall_start got %h exp 00400008", bus.imem_addr); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick(1, 0, 0, 0, 0, 0);
      n_checks++; if (bus.imem_addr !== 32'h0040_0008) $display("FAIL stall_addr[%0d] got %h exp 00400008", k, bus.imem_addr); else n_pass++;
      n_checks++; if (bus.if_id_instr !== rom[1]) $display("FAIL stall_instr[%0d] got %h exp %h", k, bus.if_id_instr, rom[1]); else n_pass++;
    end
    tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.imem_addr !== 32'h0040_000C) $display("FAIL stall_resume got %h exp 0040000c", bus.imem_addr); else n_pass++;
    n_checks++; if (bus.if_id_instr !== rom[2]) $display("FAIL stall_resume_instr got %h exp %h", bus.if_id_instr, rom[2]); else n_pass++;
  endtask

  task automatic test_redirect_priority();
    do_reset();
    repeat (5) tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.imem_addr !== 32'h0040_0010) $display("FAIL prio_start got %h exp 00400010", bus.imem_addr); else n_pass++;
    tick(1, 0, 1, 32'h0040_0040, 1, 32'h0040_0020);
    n_checks++; if (bus.imem_addr !== 32'h0040_0020) $display("FAIL prio_addr got %h exp 00400020", bus.imem_addr); else n_pass++;
    n_checks++; if (bus.if_id_valid !== 1'b0) $display("FAIL prio_valid got %b exp 0", bus.if_id_valid); else n_pass++;
    n_checks++; if (bus.if_id_instr !== 32'h0) $display("FAIL prio_nop got %h exp 0", bus.if_id_instr); else n_pass++;
    tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.if_id_instr !== rom[8]) $display("FAIL prio_next_instr got %h exp %h", bus.if_id_instr, rom[8]); else n_pass++;
    n_checks++; if (bus.if_id_pc_plus4 !== 32'h0040_0024) $display("FAIL prio_next_pc4 got %h exp 00400024", bus.if_id_pc_plus4); else n_pass++;
  endtask

  task automatic test_misalign();
    tick(0, 0, 0, 0, 1, 32'h0040_0006);
    n_checks++; if (bus.imem_addr !== 32'h0040_0004) $display("FAIL mis_addr got %h exp 00400004", bus.imem_addr); else n_pass++;
    n_checks++; if (bus.fetch_fault !== 1'b1) $display("FAIL mis_fault got %b exp 1", bus.fetch_fault); else n_pass++;
    tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.if_id_valid !== 1'b1) $display("FAIL mis_run_valid got %b exp 1", bus.if_id_valid); else n_pass++;
    n_checks++; if (bus.if_id_instr !== rom[1]) $display("FAIL mis_run_instr got %h exp %h", bus.if_id_instr, rom[1]); else n_pass++;
    n_checks++; if (bus.fetch_fault !== 1'b1) $display("FAIL mis_sticky got %b exp 1", bus.fetch_fault); else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    repeat (64) tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.imem_addr !== 32'h0040_00FC) $display("FAIL halt_last got %h exp 004000fc", bus.imem_addr); else n_pass++;
    n_checks++; if (bus.fetch_fault !== 1'b0) $display("FAIL halt_prefault got %b exp 0", bus.fetch_fault); else n_pass++;
    tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.fetch_fault !== 1'b1) $display("FAIL halt_fault got %b exp 1", bus.fetch_fault); else n_pass++;
    n_checks++; if (bus.if_id_valid !== 1'b0) $display("FAIL halt_valid got %b exp 0", bus.if_id_valid); else n_pass++;
    n_checks++; if (bus.imem_addr !== LIMIT) $display("FAIL halt_addr got %h exp %h", bus.imem_addr, LIMIT); else n_pass++;
    tick(0, 0, 0, 0, 1, BASE);
    tick(0, 1, 1, 32'h0040_0010, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.imem_addr !== LIMIT) $display("FAIL halt_hold_addr got %h exp %h", bus.imem_addr, LIMIT); else n_pass++;
    n_checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0) $display("FAIL halt_hold_if got %b/%h exp 0/0", bus.if_id_valid, bus.if_id_instr); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.imem_addr !== BASE) $display("FAIL halt_reset_addr got %h exp %h", bus.imem_addr, BASE); else n_pass++;
    n_checks++; if (bus.fetch_fault !== 1'b0) $display("FAIL halt_reset_fault got %b exp 0", bus.fetch_fault); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset_in_stall();
    do_reset();
    repeat (4) tick(0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.imem_addr !== BASE) $display("FAIL rst_stall_addr got %h exp %h", bus.imem_addr, BASE); else n_pass++;
    n_checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0 || bus.if_id_pc_plus4 !== 32'h0)
      $display("FAIL rst_stall_if got %b/%h/%h exp 0/0/0", bus.if_id_valid, bus.if_id_instr, bus.if_id_pc_plus4); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.imem_addr !== BASE || bus.if_id_valid !== 1'b0) $display("FAIL rst_stall_fill got %h/%b exp %h/0", bus.imem_addr, bus.if_id_valid, BASE); else n_pass++;
    tick(0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.if_id_instr !== rom[0] || bus.if_id_valid !== 1'b1) $display("FAIL rst_stall_first got %h/%b exp %h/1", bus.if_id_instr, bus.if_id_valid, rom[0]); else n_pass++;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 19) == 0) return $urandom;
    t = BASE + ($urandom_range(0, 63) << 2);
    if ($urandom_range(0, 3) == 0) t = t + $urandom_range(1, 3);
    return t;
  endfunction

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      if (m_halted && $urandom_range(0, 2) == 0) do_reset();
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, rand_target(),
           $urandom_range(0, 19) == 0, rand_target());
      n_checks++; if (bus.imem_addr !== m_pc) $display("FAIL rnd_addr[%0d] got %h exp %h", n, bus.imem_addr, m_pc); else n_pass++;
      n_checks++; if (bus.if_id_instr !== m_instr) $display("FAIL rnd_instr[%0d] got %h exp %h", n, bus.if_id_instr, m_instr); else n_pass++;
      n_checks++; if (bus.if_id_pc_plus4 !== m_pc4) $display("FAIL rnd_pc4[%0d] got %h exp %h", n, bus.if_id_pc_plus4, m_pc4); else n_pass++;
      n_checks++; if (bus.if_id_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %b exp %b", n, bus.if_id_valid, m_valid); else n_pass++;
      n_checks++; if (bus.fetch_fault !== m_fault) $display("FAIL rnd_fault[%0d] got %b exp %b", n, bus.fetch_fault, m_fault); else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    reset = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.branch_taken = 0; bus.jump = 0;
    bus.branch_target = 0; bus.jump_target = 0;
    model_reset();
    test_reset();
    test_fill();
    test_stall();
    test_redirect_priority();
    test_misalign();
    test_halt();
    test_reset_in_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
